// File: rtl/page_table_walker.sv
// -----------------------------------------------------------------------------
// page_table_walker
//
// Two-level page-table walker servicing TLB misses. A miss request latches
// the faulting VA and the level-1 table base, reads the level-1 PTE and then
// the level-2 (leaf) PTE through a request/response memory port, and either
// fills the TLB with the leaf PA or reports a page fault when a PTE has its
// valid bit clear. One walk is in flight at a time.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_miss_valid/i_miss_vaddr  walk request and VA to translate
//   o_miss_ready               high only while idle (request accept)
//   i_ptbr                     level-1 table base word address, sampled at accept
//   o_mem_req/o_mem_addr       PTE read request and word address
//   i_mem_ready                memory accepts the request this cycle
//   i_mem_valid/i_mem_data     read response; bit [PA_WIDTH] is the PTE valid bit
//   o_tlb_write_*              one-cycle TLB fill pulse with VA/PA
//   o_fault/o_fault_vaddr      one-cycle page-fault pulse with faulting VA
//   o_busy                     a walk is in progress
// -----------------------------------------------------------------------------
module page_table_walker #(
    parameter int VA_WIDTH = 32,
    parameter int PA_WIDTH = 32,
    parameter int L1_BITS  = 10,
    parameter int L2_BITS  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_miss_valid,
    input  logic [VA_WIDTH-1:0] i_miss_vaddr,
    output logic                o_miss_ready,
    input  logic [PA_WIDTH-1:0] i_ptbr,
    output logic                o_mem_req,
    output logic [PA_WIDTH-1:0] o_mem_addr,
    input  logic                i_mem_ready,
    input  logic                i_mem_valid,
    input  logic [PA_WIDTH:0]   i_mem_data,
    output logic                o_tlb_write_enable,
    output logic [VA_WIDTH-1:0] o_tlb_write_virtual_addr,
    output logic [PA_WIDTH-1:0] o_tlb_write_physical_addr,
    output logic                o_fault,
    output logic [VA_WIDTH-1:0] o_fault_vaddr,
    output logic                o_busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] L1_REQ  = 3'd1;
    localparam logic [2:0] L1_WAIT = 3'd2;
    localparam logic [2:0] L2_REQ  = 3'd3;
    localparam logic [2:0] L2_WAIT = 3'd4;
    localparam logic [2:0] FILL    = 3'd5;
    localparam logic [2:0] FAULT   = 3'd6;

    logic [2:0]          state;
    logic [VA_WIDTH-1:0] va_q;        // VA of the walk in progress
    logic [PA_WIDTH-1:0] base_q;      // current table base (ptbr, then L1 PTE)
    logic [PA_WIDTH-1:0] pa_q;        // leaf PA, held after the fill pulse
    logic [VA_WIDTH-1:0] fill_va_q;   // VA shown on the TLB write port
    logic [VA_WIDTH-1:0] fault_va_q;  // VA shown on the fault port

    logic [L1_BITS-1:0]  idx1;
    logic [L2_BITS-1:0]  idx2;
    logic [PA_WIDTH-1:0] idx_ext;
    logic                pte_valid;
    logic [PA_WIDTH-1:0] pte_base;

    assign idx1      = va_q[VA_WIDTH-1 -: L1_BITS];
    assign idx2      = va_q[VA_WIDTH-L1_BITS-1 -: L2_BITS];
    assign pte_valid = i_mem_data[PA_WIDTH];
    assign pte_base  = i_mem_data[PA_WIDTH-1:0];

    always_comb begin
        // NOTE: assign a default before any branch so every path drives idx_ext;
        // otherwise synthesis would infer a latch.
        idx_ext = PA_WIDTH'(idx1);
        if (state == L2_REQ) begin
            idx_ext = PA_WIDTH'(idx2);
        end
    end

    // Table base plus index wraps modulo 2^PA_WIDTH; the carry is dropped.
    assign o_mem_addr = base_q + idx_ext;

    // Moore outputs: decoded from state and registers only.
    assign o_miss_ready              = (state == IDLE);
    assign o_busy                    = (state != IDLE);
    assign o_mem_req                 = (state == L1_REQ) || (state == L2_REQ);
    assign o_tlb_write_enable        = (state == FILL);
    assign o_tlb_write_virtual_addr  = fill_va_q;
    assign o_tlb_write_physical_addr = pa_q;
    assign o_fault                   = (state == FAULT);
    assign o_fault_vaddr             = fault_va_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            va_q       <= '0;
            base_q     <= '0;
            pa_q       <= '0;
            fill_va_q  <= '0;
            fault_va_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Responses arriving here (e.g. after a reset mid-walk) are ignored.
                    if (i_miss_valid) begin
                        va_q   <= i_miss_vaddr;
                        base_q <= i_ptbr;
                        state  <= L1_REQ;
                    end
                end
                L1_REQ: begin
                    if (i_mem_ready) state <= L1_WAIT;
                end
                L1_WAIT: begin
                    if (i_mem_valid) begin
                        if (pte_valid) begin
                            base_q <= pte_base;
                            state  <= L2_REQ;
                        end else begin
                            fault_va_q <= va_q;
                            state      <= FAULT;
                        end
                    end
                end
                L2_REQ: begin
                    if (i_mem_ready) state <= L2_WAIT;
                end
                L2_WAIT: begin
                    if (i_mem_valid) begin
                        if (pte_valid) begin
                            pa_q      <= pte_base;
                            fill_va_q <= va_q;
                            state     <= FILL;
                        end else begin
                            fault_va_q <= va_q;
                            state      <= FAULT;
                        end
                    end
                end
                FILL:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// -----------------------------------------------------------------------------
// tb_page_table_walker
//
// Bench for page_table_walker. A memory responder answers PTE reads from an
// associative array with configurable ready stalls and response delay, and
// checks each accepted request address against a queue of expected
// addresses. A result monitor pops expected fills/faults from a scoreboard
// queue whenever the walker pulses o_tlb_write_enable or o_fault.
// -----------------------------------------------------------------------------
module tb_page_table_walker;

    logic        clk;
    logic        rst;
    logic        i_miss_valid;
    logic [31:0] i_miss_vaddr;
    logic        o_miss_ready;
    logic [31:0] i_ptbr;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [32:0] i_mem_data;
    logic        o_tlb_write_enable;
    logic [31:0] o_tlb_write_virtual_addr;
    logic [31:0] o_tlb_write_physical_addr;
    logic        o_fault;
    logic [31:0] o_fault_vaddr;
    logic        o_busy;

    page_table_walker dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_miss_valid             (i_miss_valid),
        .i_miss_vaddr             (i_miss_vaddr),
        .o_miss_ready             (o_miss_ready),
        .i_ptbr                   (i_ptbr),
        .o_mem_req                (o_mem_req),
        .o_mem_addr               (o_mem_addr),
        .i_mem_ready              (i_mem_ready),
        .i_mem_valid              (i_mem_valid),
        .i_mem_data               (i_mem_data),
        .o_tlb_write_enable       (o_tlb_write_enable),
        .o_tlb_write_virtual_addr (o_tlb_write_virtual_addr),
        .o_tlb_write_physical_addr(o_tlb_write_physical_addr),
        .o_fault                  (o_fault),
        .o_fault_vaddr            (o_fault_vaddr),
        .o_busy                   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        logic [31:0] va;
        logic [31:0] pa;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [32:0] mem [logic [31:0]];

    int checks    = 0;
    int failures  = 0;
    int fill_cnt  = 0;
    int fault_cnt = 0;
    int hs_cnt    = 0;

    int ready_stall = 0;
    int resp_delay  = 0;
    bit stray_pulse = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: acts on the falling edge, drives for the next rising edge.
    initial begin : responder
        bit          prev_req;
        bit          prev_rdy;
        logic [31:0] prev_addr;
        bit          resp_pend;
        int          resp_cnt;
        logic [31:0] resp_addr;
        int          stall_left;
        logic [31:0] exp_addr;
        prev_req = 0; prev_rdy = 0; prev_addr = '0;
        resp_pend = 0; resp_cnt = 0; resp_addr = '0; stall_left = 0;
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        forever begin
            @(negedge clk);
            i_mem_valid = 1'b0;
            if (prev_req && prev_rdy) begin
                hs_cnt++;
                resp_pend = 1;
                resp_cnt  = resp_delay;
                resp_addr = prev_addr;
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL mem_req_unexpected addr=%h", prev_addr);
                end else begin
                    exp_addr = addr_q.pop_front();
                    if (prev_addr !== exp_addr) begin
                        failures++;
                        $display("FAIL mem_addr got=%h expected=%h", prev_addr, exp_addr);
                    end
                end
            end
            if (resp_pend) begin
                if (resp_cnt == 0) begin
                    i_mem_valid = 1'b1;
                    i_mem_data  = mem.exists(resp_addr) ? mem[resp_addr] : 33'h0;
                    resp_pend   = 0;
                end else begin
                    resp_cnt--;
                end
            end else if (stray_pulse) begin
                i_mem_valid = 1'b1;
                i_mem_data  = {1'b1, 32'h5555_0000};
                stray_pulse = 0;
            end
            if (o_mem_req === 1'b1) begin
                if (!prev_req) stall_left = ready_stall;
                if (prev_req && !prev_rdy) begin
                    checks++;
                    if (o_mem_addr !== prev_addr) begin
                        failures++;
                        $display("FAIL mem_addr_stall_stable got=%h expected=%h", o_mem_addr, prev_addr);
                    end
                end
                if (stall_left > 0) begin
                    i_mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    i_mem_ready = 1'b1;
                end
            end else begin
                i_mem_ready = 1'b0;
            end
            prev_req  = (o_mem_req === 1'b1);
            prev_rdy  = i_mem_ready;
            prev_addr = o_mem_addr;
        end
    end

    // Result monitor: compares each fill/fault pulse against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (o_tlb_write_enable === 1'b1 || o_fault === 1'b1)) begin
                if (o_tlb_write_enable === 1'b1) fill_cnt++;
                if (o_fault === 1'b1) fault_cnt++;
                checks++;
                if (exp_q.size() == 0 || (o_tlb_write_enable && o_fault)) begin
                    failures++;
                    $display("FAIL sb_unexpected we=%b fault=%b va=%h pa=%h fva=%h pending=%0d",
                             o_tlb_write_enable, o_fault, o_tlb_write_virtual_addr,
                             o_tlb_write_physical_addr, o_fault_vaddr, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_fault) begin
                        if (o_fault !== 1'b1 || o_fault_vaddr !== e.va) begin
                            failures++;
                            $display("FAIL sb_fault got fault=%b va=%h expected fault=1 va=%h",
                                     o_fault, o_fault_vaddr, e.va);
                        end
                    end else if (o_tlb_write_enable !== 1'b1 || o_tlb_write_virtual_addr !== e.va ||
                                 o_tlb_write_physical_addr !== e.pa) begin
                        failures++;
                        $display("FAIL sb_fill got we=%b va=%h pa=%h expected we=1 va=%h pa=%h",
                                 o_tlb_write_enable, o_tlb_write_virtual_addr,
                                 o_tlb_write_physical_addr, e.va, e.pa);
                    end
                end
            end
        end
    end

    task automatic push_fill(input logic [31:0] va, input logic [31:0] pa);
        exp_t e;
        e.is_fault = 0; e.va = va; e.pa = pa;
        exp_q.push_back(e);
    endtask

    task automatic push_fault(input logic [31:0] va);
        exp_t e;
        e.is_fault = 1; e.va = va; e.pa = '0;
        exp_q.push_back(e);
    endtask

    // Present a miss and return just after the accepting rising edge.
    task automatic issue_miss(input logic [31:0] va, input logic [31:0] ptbr, input bit hold);
        int n = 0;
        i_miss_valid = 1'b1;
        i_miss_vaddr = va;
        i_ptbr       = ptbr;
        while (o_miss_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (o_miss_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL miss_accept_timeout va=%h", va);
        end
        @(posedge clk);
        #1;
        if (!hold) i_miss_valid = 1'b0;
    endtask

    task automatic wait_walk_done(input string name, input int target);
        int n = 0;
        while ((fill_cnt + fault_cnt) < target && n < 200) begin
            tick();
            n++;
        end
        if ((fill_cnt + fault_cnt) < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout events=%0d expected=%0d", name, fill_cnt + fault_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_miss_valid = 1'b0;
        i_miss_vaddr = '0;
        i_ptbr = '0;
        repeat (3) tick();
        checks++;
        if ({o_miss_ready, o_busy, o_mem_req, o_tlb_write_enable, o_fault} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got ready,busy,req,we,fault=%b expected=10000",
                     {o_miss_ready, o_busy, o_mem_req, o_tlb_write_enable, o_fault});
        end
        checks++;
        if ({o_mem_addr, o_tlb_write_virtual_addr, o_tlb_write_physical_addr, o_fault_vaddr} !== 128'h0) begin
            failures++;
            $display("FAIL reset_regs addr=%h va=%h pa=%h fva=%h expected all 0",
                     o_mem_addr, o_tlb_write_virtual_addr, o_tlb_write_physical_addr, o_fault_vaddr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        mem[32'h1001] = {1'b1, 32'h0000_2000};
        mem[32'h2003] = {1'b1, 32'h8000_0ABC};
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        push_fill(32'h0040_3ABC, 32'h8000_0ABC);
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            case (c)
                1: begin
                    checks++;
                    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1001 || o_miss_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL nominal_c1 req=%b addr=%h ready=%b expected req=1 addr=1001 ready=0",
                                 o_mem_req, o_mem_addr, o_miss_ready);
                    end
                end
                3: begin
                    checks++;
                    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h2003) begin
                        failures++;
                        $display("FAIL nominal_c3 req=%b addr=%h expected req=1 addr=2003", o_mem_req, o_mem_addr);
                    end
                end
                5: begin
                    checks++;
                    if (o_tlb_write_enable !== 1'b1) begin
                        failures++;
                        $display("FAIL nominal_fill_cycle5 we=%b expected=1", o_tlb_write_enable);
                    end
                end
                default: begin
                    checks++;
                    if (o_tlb_write_enable !== 1'b0 || o_busy !== (c != 6)) begin
                        failures++;
                        $display("FAIL nominal_c%0d we=%b busy=%b expected we=0 busy=%b",
                                 c, o_tlb_write_enable, o_busy, c != 6);
                    end
                end
            endcase
        end
        tick();
        checks++;
        if (o_tlb_write_virtual_addr !== 32'h0040_3ABC || o_tlb_write_physical_addr !== 32'h8000_0ABC) begin
            failures++;
            $display("FAIL nominal_hold va=%h pa=%h expected va=00403abc pa=80000abc",
                     o_tlb_write_virtual_addr, o_tlb_write_physical_addr);
        end
    endtask

    task automatic test_l1_fault();
        int hs0 = hs_cnt;
        int f0  = fill_cnt;
        int t0  = fill_cnt + fault_cnt;
        mem[32'h1001] = {1'b0, 32'hDEAD_BEEF};
        addr_q.push_back(32'h1001);
        push_fault(32'h0040_3ABC);
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 0);
        wait_walk_done("l1_fault", t0 + 1);
        repeat (4) tick();
        checks++;
        if (hs_cnt - hs0 !== 1 || fill_cnt !== f0) begin
            failures++;
            $display("FAIL l1_fault_side reqs=%0d fills=%0d expected reqs=1 fills=0", hs_cnt - hs0, fill_cnt - f0);
        end
        checks++;
        if (o_fault !== 1'b0 || o_fault_vaddr !== 32'h0040_3ABC) begin
            failures++;
            $display("FAIL l1_fault_hold fault=%b fva=%h expected fault=0 fva=00403abc", o_fault, o_fault_vaddr);
        end
    endtask

    task automatic test_l2_fault();
        int hs0 = hs_cnt;
        int f0  = fill_cnt;
        int t0  = fill_cnt + fault_cnt;
        mem[32'h1001] = {1'b1, 32'h0000_2000};
        mem[32'h2003] = {1'b0, 32'h8000_0ABC};
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        push_fault(32'h0040_3ABC);
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 0);
        wait_walk_done("l2_fault", t0 + 1);
        repeat (2) tick();
        checks++;
        if (hs_cnt - hs0 !== 2 || fill_cnt !== f0) begin
            failures++;
            $display("FAIL l2_fault_side reqs=%0d fills=%0d expected reqs=2 fills=0", hs_cnt - hs0, fill_cnt - f0);
        end
    endtask

    task automatic test_backpressure();
        int t0 = fill_cnt + fault_cnt;
        int req_cycles = 0;
        bit ready_bad = 0;
        int n = 0;
        mem[32'h1001] = {1'b1, 32'h0000_2000};
        mem[32'h2003] = {1'b1, 32'h8000_0ABC};
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        push_fill(32'h0040_3ABC, 32'h8000_0ABC);
        ready_stall = 4;
        resp_delay  = 3;
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 0);
        while ((fill_cnt + fault_cnt) < t0 + 1 && n < 200) begin
            tick();
            n++;
            if (o_mem_req === 1'b1) req_cycles++;
            if (o_miss_ready !== 1'b0) ready_bad = 1;
        end
        checks++;
        if ((fill_cnt + fault_cnt) < t0 + 1) begin
            failures++;
            $display("FAIL backpressure_timeout events=%0d expected=%0d", fill_cnt + fault_cnt, t0 + 1);
        end
        checks++;
        if (req_cycles !== 10 || ready_bad) begin
            failures++;
            $display("FAIL backpressure_req_cycles got=%0d ready_bad=%0b expected=10 ready_bad=0", req_cycles, ready_bad);
        end
        ready_stall = 0;
        resp_delay  = 0;
        tick();
    endtask

    task automatic test_wrap_stray();
        int t0 = fill_cnt + fault_cnt;
        stray_pulse = 1;
        repeat (2) tick();
        checks++;
        if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_miss_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_idle busy=%b req=%b ready=%b expected busy=0 req=0 ready=1",
                     o_busy, o_mem_req, o_miss_ready);
        end
        mem[32'h0000_0001] = {1'b1, 32'h0000_3000};
        mem[32'h0000_3005] = {1'b1, 32'h1234_5000};
        addr_q.push_back(32'h0000_0001);
        addr_q.push_back(32'h0000_3005);
        push_fill(32'h0080_5000, 32'h1234_5000);
        issue_miss(32'h0080_5000, 32'hFFFF_FFFF, 0);
        tick();
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_0001) begin
            failures++;
            $display("FAIL wrap_addr req=%b addr=%h expected req=1 addr=00000001", o_mem_req, o_mem_addr);
        end
        wait_walk_done("wrap", t0 + 1);
        tick();
    endtask

    task automatic test_back_to_back();
        int t0 = fill_cnt + fault_cnt;
        mem[32'h1001] = {1'b1, 32'h0000_2000};
        mem[32'h2003] = {1'b1, 32'h8000_0ABC};
        mem[32'h1003] = {1'b1, 32'h0000_4000};
        mem[32'h4002] = {1'b1, 32'h0000_7000};
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        addr_q.push_back(32'h1003);
        addr_q.push_back(32'h4002);
        push_fill(32'h0040_3ABC, 32'h8000_0ABC);
        push_fill(32'h00C0_2000, 32'h0000_7000);
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 1);
        wait_walk_done("b2b_first", t0 + 1);
        i_miss_vaddr = 32'h00C0_2000;
        tick();
        checks++;
        if (o_miss_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle ready=%b busy=%b expected ready=1 busy=0", o_miss_ready, o_busy);
        end
        @(posedge clk);
        #1;
        i_miss_valid = 1'b0;
        tick();
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1003) begin
            failures++;
            $display("FAIL b2b_second_req req=%b addr=%h expected req=1 addr=1003", o_mem_req, o_mem_addr);
        end
        wait_walk_done("b2b_second", t0 + 2);
        tick();
    endtask

    task automatic test_reset_midwalk();
        int hs0 = hs_cnt;
        int f0  = fill_cnt;
        int x0  = fault_cnt;
        int n   = 0;
        mem[32'h1001] = {1'b1, 32'h0000_2000};
        mem[32'h2003] = {1'b1, 32'h8000_0ABC};
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        push_fill(32'h0040_3ABC, 32'h8000_0ABC);
        resp_delay = 1;
        issue_miss(32'h0040_3ABC, 32'h0000_1000, 1);
        while (hs_cnt < hs0 + 2 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (hs_cnt < hs0 + 2) begin
            failures++;
            $display("FAIL rst_mid_reach_l2 reqs=%0d expected=2", hs_cnt - hs0);
        end
        rst = 1'b1;
        tick();
        resp_delay = 0;
        checks++;
        if (o_busy !== 1'b0 || o_miss_ready !== 1'b1 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle busy=%b ready=%b req=%b expected busy=0 ready=1 req=0",
                     o_busy, o_miss_ready, o_mem_req);
        end
        checks++;
        if (fill_cnt !== f0 || fault_cnt !== x0) begin
            failures++;
            $display("FAIL rst_mid_no_event fills=%0d faults=%0d expected 0 0", fill_cnt - f0, fault_cnt - x0);
        end
        exp_q.delete();
        addr_q.push_back(32'h1001);
        addr_q.push_back(32'h2003);
        push_fill(32'h0040_3ABC, 32'h8000_0ABC);
        rst = 1'b0;
        @(posedge clk);
        #1;
        i_miss_valid = 1'b0;
        tick();
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1001) begin
            failures++;
            $display("FAIL rst_mid_rewalk req=%b addr=%h expected req=1 addr=1001", o_mem_req, o_mem_addr);
        end
        wait_walk_done("rst_mid_rewalk", f0 + x0 + 1);
        repeat (2) tick();
        checks++;
        if (fill_cnt !== f0 + 1 || fault_cnt !== x0 || exp_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_final fills=%0d faults=%0d pending=%0d/%0d expected 1 0 0/0",
                     fill_cnt - f0, fault_cnt - x0, exp_q.size(), addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_l1_fault();
        test_l2_fault();
        test_backpressure();
        test_wrap_stray();
        test_back_to_back();
        test_reset_midwalk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
